clk_period_meter: RTL and testbench

Measures the period of the divided PLL feedback clock in units of `clk_in` cycles and flags whether it matches the programmed division ratio. It is the receive side of the clock divider: the divider emits `clk_out`, and this block samples that signal asynchronously and reports the averaged ratio. It sits in the PLL digital test/lock-detect path and feeds status registers.

---
 rtl/clk_meas_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 27 ++
 rtl/clk_period_meter.sv | 156 +++++++++++++++
 tb/tb_clk_period_meter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and default parameters for the clock period meter.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } meas_state_t;

    localparam int DEF_AVG_LOG2 = 2;
    localparam int DEF_TOL      = 0;

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer for an asynchronous level, with a rising-edge pulse
// taken from the last two stages so the pulse is glitch-free.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clk_period_meter.sv
// Measures the averaged period of an asynchronous divided clock in clk_in
// cycles and flags whether it is within TOL of the programmed ratio.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int N        = 4,
    parameter int CW       = 16,
    parameter int AVG_LOG2 = DEF_AVG_LOG2,
    parameter int TOL      = DEF_TOL
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          div_clk,
    input  logic          enable,
    input  logic [N-1:0]  expected,
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          in_range,
    output logic          overflow
);

    localparam logic [CW-1:0] TOL_C = CW'(TOL);

    meas_state_t         state_q, state_d;
    logic [CW-1:0]       acc_q, acc_d;
    logic [AVG_LOG2-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0]       period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                in_range_q, in_range_d;
    logic                overflow_q, overflow_d;
    logic                enable_q, enable_d;

    logic                rise;
    logic                window_done;
    logic                acc_full;
    logic [CW-1:0]       avg;
    logic [CW-1:0]       exp_ext;
    logic [CW-1:0]       abs_diff;
    logic                range_ok;

    sync_edge_det u_sync (
        .clk      (clk_in),
        .rst      (rst),
        .async_in (div_clk),
        .rise     (rise)
    );

    assign window_done = rise && (&pcnt_q);
    assign acc_full    = &acc_q;
    assign avg         = acc_q >> AVG_LOG2;
    assign exp_ext     = {{(CW-N){1'b0}}, expected};
    // Unsigned magnitude of the difference, ordered so it can never wrap.
    assign abs_diff    = (avg >= exp_ext) ? (avg - exp_ext) : (exp_ext - avg);
    assign range_ok    = (abs_diff <= TOL_C);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ARM;
                ST_ARM:     if (rise) state_d = ST_MEASURE;
                ST_MEASURE: if (!window_done && acc_full) state_d = ST_ARM;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d          = acc_q;
        pcnt_d         = pcnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        in_range_d     = in_range_q;
        overflow_d     = overflow_q;
        enable_d       = enable;
        if (enable && !enable_q) begin
            overflow_d = 1'b0;
        end
        if (!enable) begin
            acc_d  = '0;
            pcnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_d  = '0;
                    pcnt_d = '0;
                end
                ST_ARM: begin
                    if (rise) begin
                        acc_d  = CW'(1);
                        pcnt_d = '0;
                    end
                end
                ST_MEASURE: begin
                    // Count starts at 1 so acc equals k*P exactly at the k-th edge.
                    if (window_done) begin
                        period_d       = avg;
                        period_valid_d = 1'b1;
                        in_range_d     = range_ok;
                        acc_d          = CW'(1);
                        pcnt_d         = '0;
                    end else if (acc_full) begin
                        overflow_d = 1'b1;
                        period_d   = '1;
                        in_range_d = 1'b0;
                    end else if (rise) begin
                        acc_d  = acc_q + 1'b1;
                        pcnt_d = pcnt_q + 1'b1;
                    end else begin
                        acc_d = acc_q + 1'b1;
                    end
                end
                default: begin
                    acc_d  = '0;
                    pcnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            acc_q          <= '0;
            pcnt_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            in_range_q     <= 1'b0;
            overflow_q     <= 1'b0;
            enable_q       <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            pcnt_q         <= pcnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            in_range_q     <= in_range_d;
            overflow_q     <= overflow_d;
            enable_q       <= enable_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign in_range     = in_range_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench: three meters with TOL 0/1/2 share one div_clk source.
module tb_clk_period_meter;

    localparam int N  = 4;
    localparam int CW = 16;

    logic          clk_in   = 1'b0;
    logic          rst      = 1'b1;
    logic          div_clk  = 1'b0;
    logic          enable   = 1'b0;
    logic [N-1:0]  expected = '0;
    logic [CW-1:0] period0, period1, period2;
    logic          pv0, pv1, pv2, ir0, ir1, ir2, ov0, ov1, ov2;

    int checks   = 0;
    int passes   = 0;
    int cyc      = 0;
    int rise_cyc = 0;

    typedef struct {
        logic [CW-1:0] p0, p1, p2;
        logic          ir0, ir1, ir2, ov;
        logic [2:0]    v;
        int            cyc;
    } cap_t;
    cap_t caps[$];

    typedef struct {
        int   hi, lo, hi2, lo2, expv, ep;
        logic e0, e1, e2;
    } vec_t;
    vec_t vecs[8];

    clk_period_meter #(.N(N), .CW(CW), .AVG_LOG2(2), .TOL(0)) dut0 (
        .clk_in(clk_in), .rst(rst), .div_clk(div_clk), .enable(enable), .expected(expected),
        .period(period0), .period_valid(pv0), .in_range(ir0), .overflow(ov0));
    clk_period_meter #(.N(N), .CW(CW), .AVG_LOG2(2), .TOL(1)) dut1 (
        .clk_in(clk_in), .rst(rst), .div_clk(div_clk), .enable(enable), .expected(expected),
        .period(period1), .period_valid(pv1), .in_range(ir1), .overflow(ov1));
    clk_period_meter #(.N(N), .CW(CW), .AVG_LOG2(2), .TOL(2)) dut2 (
        .clk_in(clk_in), .rst(rst), .div_clk(div_clk), .enable(enable), .expected(expected),
        .period(period2), .period_valid(pv2), .in_range(ir2), .overflow(ov2));

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (!rst && (pv0 || pv1 || pv2)) begin
            caps.push_back('{p0: period0, p1: period1, p2: period2, ir0: ir0, ir1: ir1,
                             ir2: ir2, ov: ov0, v: {pv0, pv1, pv2}, cyc: cyc});
            $display("pulse @%0d: period=%0d in_range=%b%b%b overflow=%b", cyc, period0, ir0, ir1, ir2, ov0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic drive_period(input int hi, input int lo);
        div_clk  = 1'b1;
        rise_cyc = cyc;
        wait_n(hi);
        div_clk = 1'b0;
        wait_n(lo);
    endtask

    // Reference: averaged period is the floor of the window's summed periods / 4.
    function automatic logic model_in_range(input int avg, input int e, input int tol);
        int d;
        d = (avg > e) ? (avg - e) : (e - avg);
        return d <= tol;
    endfunction

    task automatic check_cap(input string name, input int idx, input int ep,
                             input logic e0, input logic e1, input logic e2);
        if (idx >= caps.size()) begin
            chk({name, "_present"}, caps.size(), idx + 1);
        end else begin
            chk({name, "_period"}, caps[idx].p0, ep);
            chk({name, "_period_t2"}, caps[idx].p2, caps[idx].p1);
            chk({name, "_ir0"}, caps[idx].ir0, e0);
            chk({name, "_ir1"}, caps[idx].ir1, e1);
            chk({name, "_ir2"}, caps[idx].ir2, e2);
            chk({name, "_valid_all"}, caps[idx].v, 3'b111);
        end
    endtask

    task automatic start_meas(input int e);
        enable   = 1'b0;
        expected = 4'(e);
        wait_n(4);
        caps.delete();
        enable = 1'b1;
        wait_n(3);
    endtask

    initial begin
        int his[9];
        int los[9];
        int t;
        int sum;
        int ep;
        int e;
        int edge_c;

        vecs[0] = '{4, 4, 4, 4, 8, 8, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{5, 5, 5, 5, 8, 10, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{5, 4, 5, 6, 10, 10, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{3, 3, 3, 3, 7, 6, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{2, 2, 2, 2, 15, 4, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8, 8, 8, 8, 15, 16, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{3, 4, 3, 3, 6, 6, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{3, 4, 3, 4, 0, 7, 1'b0, 1'b0, 1'b0};

        wait_n(3);
        chk("rst_period", period0, 0);
        chk("rst_valid", pv0, 0);
        chk("rst_in_range", ir0, 0);
        chk("rst_overflow", ov0, 0);
        rst = 1'b0;
        wait_n(2);

        foreach (vecs[i]) begin
            start_meas(vecs[i].expv);
            for (int k = 0; k < 5; k++) begin
                if (k % 2 == 0) drive_period(vecs[i].hi, vecs[i].lo);
                else drive_period(vecs[i].hi2, vecs[i].lo2);
            end
            wait_n(4);
            chk($sformatf("vec%0d_count", i), caps.size(), 1);
            check_cap($sformatf("vec%0d", i), 0, vecs[i].ep, vecs[i].e0, vecs[i].e1, vecs[i].e2);
        end

        // Back-to-back windows: first pulse latency and 32-cycle spacing.
        start_meas(8);
        edge_c = 0;
        for (int k = 0; k < 13; k++) begin
            drive_period(4, 4);
            if (k == 4) edge_c = rise_cyc;
        end
        wait_n(4);
        chk("b2b_count", caps.size(), 3);
        if (caps.size() == 3) begin
            chk("b2b_latency", ((caps[0].cyc - edge_c) >= 3) && ((caps[0].cyc - edge_c) <= 4), 1);
            chk("b2b_spacing1", caps[1].cyc - caps[0].cyc, 32);
            chk("b2b_spacing2", caps[2].cyc - caps[1].cyc, 32);
            for (int w = 0; w < 3; w++) check_cap($sformatf("b2b%0d", w), w, 8, 1'b1, 1'b1, 1'b1);
        end

        // Randomized periods against the arithmetic reference.
        for (int r = 0; r < 5; r++) begin
            e = int'($urandom_range(0, 15));
            for (int k = 0; k < 9; k++) begin
                his[k] = int'($urandom_range(2, 7));
                los[k] = int'($urandom_range(2, 7));
            end
            start_meas(e);
            for (int k = 0; k < 9; k++) drive_period(his[k], los[k]);
            wait_n(4);
            chk($sformatf("rnd%0d_count", r), caps.size(), 2);
            for (int w = 0; w < 2; w++) begin
                sum = 0;
                for (int k = 4 * w; k < 4 * w + 4; k++) sum += his[k] + los[k];
                ep = sum / 4;
                check_cap($sformatf("rnd%0d_w%0d", r, w), w, ep, model_in_range(ep, e, 0),
                          model_in_range(ep, e, 1), model_in_range(ep, e, 2));
            end
        end

        // Stopped clock: saturation and sticky overflow.
        start_meas(8);
        for (int k = 0; k < 9; k++) drive_period(4, 4);
        wait_n(4);
        chk("ovf_pre_count", caps.size(), 2);
        caps.delete();
        t = 0;
        while (!ov0 && t < 70000) begin
            wait_n(1);
            t++;
        end
        chk("ovf_set", ov0, 1);
        chk("ovf_not_early", t > 65000, 1);
        chk("ovf_period", period0, 16'hFFFF);
        chk("ovf_in_range0", ir0, 0);
        chk("ovf_in_range2", ir2, 0);
        chk("ovf_set_t2", ov2, 1);
        chk("ovf_no_pulse", caps.size(), 0);
        for (int k = 0; k < 5; k++) drive_period(4, 4);
        wait_n(4);
        chk("ovf_restart_count", caps.size(), 1);
        check_cap("ovf_restart", 0, 8, 1'b1, 1'b1, 1'b1);
        if (caps.size() > 0) chk("ovf_sticky_at_pulse", caps[0].ov, 1);
        enable = 1'b0;
        wait_n(3);
        chk("ovf_hold_idle", ov0, 1);
        chk("ovf_idle_sticky_t1", ov1, 1);
        enable = 1'b1;
        wait_n(2);
        chk("ovf_cleared", ov0, 0);

        // Drop enable mid-window at P=10; previous result 8 must hold.
        caps.delete();
        drive_period(5, 5);
        drive_period(5, 5);
        div_clk = 1'b1;
        wait_n(2);
        enable = 1'b0;
        wait_n(3);
        div_clk = 1'b0;
        wait_n(5);
        for (int k = 0; k < 3; k++) drive_period(5, 5);
        wait_n(4);
        chk("drop_no_pulse", caps.size(), 0);
        chk("drop_period_hold", period0, 8);
        chk("drop_in_range_hold", ir0, 1);
        start_meas(8);
        for (int k = 0; k < 5; k++) drive_period(3, 3);
        wait_n(4);
        chk("reen_count", caps.size(), 1);
        check_cap("reen", 0, 6, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of MEASURE.
        caps.delete();
        drive_period(5, 5);
        drive_period(5, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_period", period0, 0);
        chk("arst_valid", pv0, 0);
        chk("arst_in_range2", ir2, 0);
        chk("arst_overflow", ov0, 0);
        wait_n(2);
        rst = 1'b0;
        wait_n(3);
        for (int k = 0; k < 5; k++) drive_period(4, 4);
        wait_n(4);
        chk("arst_recover_count", caps.size(), 1);
        check_cap("arst_recover", 0, 8, 1'b1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
